// File: rtl/dac_arb_pkg.sv
// Shared definitions for the DAC request arbiter.
//   DAC_DW      : DAC frame width of the SPI driver
//   arb_state_e : arbiter FSM states
//   clog2       : index/counter width helper (never returns less than 1)
package dac_arb_pkg;

  localparam int DAC_DW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_RESP,
    S_FAIL
  } arb_state_e;

  // Width needed to hold values 0..value-1; at least one bit so that
  // degenerate sizes still give a legal vector.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dac_req_arbiter_rr.sv
// Combinational round-robin picker.
//   req_i   : N request lines
//   ptr_i   : index with the highest priority this round
//   grant_o : one-hot winner (all zero when no request)
//   idx_o   : binary index of the winner
//   valid_o : at least one request present
// The winner is the first set request at or above ptr_i; when none exists
// above the pointer the search wraps and the lowest set request wins.
module rr_arbiter
  import dac_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic [N-1:0]          upper_mask;
  logic [N-1:0]          masked_req;
  logic [N-1:0]          search_req;
  logic [PW-1:0][N-1:0]  idx_bits;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign upper_mask[gi] = (PW'(gi) >= ptr_i);
  end

  assign masked_req = req_i & upper_mask;
  assign search_req = (|masked_req) ? masked_req : req_i;

  // Isolate the lowest set bit of the search vector.
  assign grant_o = search_req & (~search_req + N'(1));
  assign valid_o = |req_i;

  // One-hot to binary: bit gb of the index is set when the winner's
  // position has bit gb set.
  for (genvar gb = 0; gb < PW; gb++) begin : g_idx_bit
    for (genvar gi = 0; gi < N; gi++) begin : g_idx_term
      localparam logic [PW-1:0] GI = PW'(gi);
      assign idx_bits[gb][gi] = grant_o[gi] & GI[gb];
    end
    assign idx_o[gb] = |idx_bits[gb];
  end

endmodule

// File: rtl/dac_req_arbiter.sv
// Shares one SPI DAC driver among N_REQ requesters, round-robin.
//   clk, rst_n      : driver clock, synchronous active-low reset
//   req, wdata      : level requests and per-requester codes (i at [i*DW +: DW])
//   ack, err        : one-hot single-cycle completion / timeout pulses
//   rdata           : driver readback, updated in the ack cycle, held otherwise
//   busy            : high from grant through the ack/err cycle
//   dac_en          : start request to the driver, held until accepted
//   dac_value       : latched code of the current winner
//   dac_nsync       : driver frame sync (low = frame accepted)
//   dac_done        : driver completion pulse, dac_rdback valid with it
module dac_req_arbiter
  import dac_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = DAC_DW,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    err,
  output logic [DW-1:0]       rdata,
  output logic                busy,
  output logic                dac_en,
  output logic [DW-1:0]       dac_value,
  input  logic                dac_nsync,
  input  logic                dac_done,
  input  logic [DW-1:0]       dac_rdback
);

  localparam int PW = clog2(N_REQ);
  localparam int TW = clog2(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     gid_q, gid_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              dac_en_q, dac_en_d;
  logic [DW-1:0]     dac_value_q, dac_value_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              busy_q, busy_d;

  logic [N_REQ-1:0]  grant;
  logic [PW-1:0]     grant_idx;
  logic              grant_valid;
  logic [DW-1:0]     wdata_sel;
  logic [N_REQ-1:0]  wdata_col [DW];
  logic [N_REQ-1:0]  gid_onehot;
  logic [PW-1:0]     ptr_after;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .valid_o (grant_valid)
  );

  // AND-OR mux of the winner's code, one column per data bit.
  for (genvar gb = 0; gb < DW; gb++) begin : g_wsel_bit
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_wsel_req
      assign wdata_col[gb][gi] = wdata[gi*DW + gb];
    end
    assign wdata_sel[gb] = |(wdata_col[gb] & grant);
  end

  assign gid_onehot = N_REQ'(1) << gid_q;
  assign ptr_after  = (gid_q == PW'(N_REQ - 1)) ? '0 : gid_q + PW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gid_q       <= '0;
      ptr_q       <= '0;
      timer_q     <= '0;
      dac_en_q    <= 1'b0;
      dac_value_q <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gid_q       <= gid_d;
      ptr_q       <= ptr_d;
      timer_q     <= timer_d;
      dac_en_q    <= dac_en_d;
      dac_value_q <= dac_value_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gid_d       = gid_q;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    dac_en_d    = dac_en_q;
    dac_value_d = dac_value_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        // A stale dac_done here is deliberately ignored.
        if (grant_valid) begin
          gid_d       = grant_idx;
          dac_value_d = wdata_sel;
          busy_d      = 1'b1;
          timer_d     = '0;
          dac_en_d    = 1'b1;
          state_d     = S_START;
        end
      end
      S_START, S_BUSY: begin
        // Completion wins over everything, including a done that arrives
        // before nsync was ever seen low; the watchdog comes next.
        if (dac_done) begin
          dac_en_d = 1'b0;
          rdata_d  = dac_rdback;
          state_d  = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          dac_en_d = 1'b0;
          state_d  = S_FAIL;
        end else begin
          timer_d = timer_q + TW'(1);
          // en stays high until the driver actually takes the frame, so a
          // request made during the driver's post-frame gap is not lost.
          if (state_q == S_START && !dac_nsync) begin
            dac_en_d = 1'b0;
            state_d  = S_BUSY;
          end
        end
      end
      S_RESP, S_FAIL: begin
        ptr_d   = ptr_after;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        dac_en_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign ack       = (state_q == S_RESP) ? gid_onehot : '0;
  assign err       = (state_q == S_FAIL) ? gid_onehot : '0;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign dac_en    = dac_en_q;
  assign dac_value = dac_value_q;

endmodule

// File: tb/tb_dac_req_arbiter.sv
module tb_dac_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    ack;
  logic [N-1:0]    err;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            dac_en;
  logic [DW-1:0]   dac_value;
  logic            dac_nsync = 1'b1;
  logic            dac_done = 1'b0;
  logic [DW-1:0]   dac_rdback = '0;

  dac_req_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .wdata      (wdata),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .busy       (busy),
    .dac_en     (dac_en),
    .dac_value  (dac_value),
    .dac_nsync  (dac_nsync),
    .dac_done   (dac_done),
    .dac_rdback (dac_rdback)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver model ----------------
  // mode 0: nsync low one cycle after en, done 33 cycles later, rdback = ~value
  // mode 1: driver dead (nsync never low, no done)
  // mode 2: done after 3 cycles while nsync still high
  int   mode = 0;
  logic m_active = 1'b0;
  int   m_cnt = 0;
  int   stray_req = 0;
  int   stray_ack = 0;

  always @(negedge clk) begin
    dac_done = 1'b0;
    if (!rst_n || (m_active && !busy)) begin
      m_active  = 1'b0;
      dac_nsync = 1'b1;
    end else if (m_active) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == ((mode == 2) ? 3 : 33)) begin
        dac_done   = 1'b1;
        dac_rdback = ~dac_value;
        dac_nsync  = 1'b1;
        m_active   = 1'b0;
      end
    end else if (dac_en && mode != 1) begin
      m_active = 1'b1;
      m_cnt    = 0;
      if (mode == 0) dac_nsync = 1'b0;
    end else if (stray_req != stray_ack) begin
      stray_ack  = stray_req;
      dac_done   = 1'b1;
      dac_rdback = 16'h1234;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          id;
    logic        is_err;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int          id;
    logic [15:0] wdata;
    logic [15:0] exp_value;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic is_err, input logic [15:0] rd);
    exp_t e;
    e.id = id;
    e.is_err = is_err;
    e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic set_word(input int id, input logic [15:0] w);
    wdata[id*DW +: DW] = w;
  endtask

  task automatic wait_event(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if ((ack | err) != '0) begin
        seen = 1'b1;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL resp_timeout: no ack/err within %0d cycles, required one", max_cycles);
  endtask

  task automatic check_resp();
    exp_t         e;
    logic [N-1:0] oh;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL resp_unexpected: ack=%b err=%b, required no response", ack, err);
      return;
    end
    e  = sb.pop_front();
    oh = 4'b0001 << e.id;
    $display("[TB] resp id=%0d kind=%s ack=%b err=%b rdata=0x%04h (cycle %0d)",
             e.id, e.is_err ? "err" : "ack", ack, err, rdata, cyc);
    chk("resp_ack", ack, e.is_err ? 4'b0000 : oh);
    chk("resp_err", err, e.is_err ? oh : 4'b0000);
    chk("resp_rdata", rdata, e.rdata);
    chk("resp_busy", busy, 1'b1);
  endtask

  task automatic wait_resp(input int max_cycles);
    bit s;
    wait_event(max_cycles, s);
    if (s) check_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int t0;
    bit seen;

    vecs[0] = '{id: 2, wdata: 16'h8000, exp_value: 16'h8000, exp_rdata: 16'h7FFF};
    vecs[1] = '{id: 0, wdata: 16'h0000, exp_value: 16'h0000, exp_rdata: 16'hFFFF};
    vecs[2] = '{id: 1, wdata: 16'h1234, exp_value: 16'h1234, exp_rdata: 16'hEDCB};
    vecs[3] = '{id: 3, wdata: 16'hFFFF, exp_value: 16'hFFFF, exp_rdata: 16'h0000};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_err", err, 4'b0000);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dac_en", dac_en, 1'b0);
    chk("rst_dac_value", dac_value, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // single-requester vectors
    for (int v = 0; v < 4; v++) begin
      wdata = '0;
      set_word(vecs[v].id, vecs[v].wdata);
      req = '0;
      req[vecs[v].id] = 1'b1;
      push_exp(vecs[v].id, 1'b0, vecs[v].exp_rdata);
      $display("[TB] vec %0d: req[%0d] wdata=0x%04h", v, vecs[v].id, vecs[v].wdata);
      @(negedge clk);
      chk("grant_busy", busy, 1'b1);
      chk("grant_dac_en", dac_en, 1'b1);
      chk("grant_dac_value", dac_value, vecs[v].exp_value);
      wait_resp(200);
      req = '0;
      @(negedge clk);
      chk("after_busy", busy, 1'b0);
      chk("after_ack", ack, 4'b0000);
    end

    // all four requesting continuously: 0,1,2,3,0
    for (int i = 0; i < N; i++) set_word(i, 16'(16'h1111 * (i + 1)));
    for (int k = 0; k < 5; k++) begin
      int id;
      id = k % N;
      push_exp(id, 1'b0, ~(16'(16'h1111 * (id + 1))));
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_resp(200);
      if (k == 4) req = '0;
      @(negedge clk);
      chk("rr_ack_width", ack, 4'b0000);
      chk("rr_idle_gap", busy, 1'b0);
    end

    // dead driver: requester 1 times out, requester 2 then served
    mode = 1;
    wdata = '0;
    set_word(1, 16'h0BAD);
    set_word(2, 16'h2222);
    push_exp(1, 1'b1, 16'hEEEE);
    push_exp(2, 1'b0, 16'hDDDD);
    req = 4'b0110;
    @(negedge clk);
    t0 = cyc;
    chk("to_grant_value", dac_value, 16'h0BAD);
    wait_event(200, seen);
    if (seen) begin
      chk("to_cycles", 32'(cyc - t0), 32'(TO));
      chk("to_dac_en", dac_en, 1'b0);
      check_resp();
    end
    req[1] = 1'b0;
    mode = 0;
    wait_resp(200);
    req = '0;
    @(negedge clk);

    // reset in the middle of a transfer
    wdata = '0;
    set_word(3, 16'h3333);
    push_exp(3, 1'b0, 16'hCCCC);
    req = 4'b1000;
    @(negedge clk);
    repeat (10) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    req = '0;
    sb.delete();
    @(negedge clk);
    chk("mrst_dac_en", dac_en, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_rdata", rdata, 16'h0000);
    chk("mrst_ack_err", {ack, err}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    // pointer back at 0: requester 1 wins over 3
    set_word(1, 16'h4444);
    set_word(3, 16'h5555);
    push_exp(1, 1'b0, 16'hBBBB);
    push_exp(3, 1'b0, 16'hAAAA);
    req = 4'b1010;
    wait_resp(200);
    req[1] = 1'b0;
    wait_resp(200);
    req = '0;
    @(negedge clk);

    // done arrives while still in START
    mode = 2;
    wdata = '0;
    set_word(0, 16'h5A5A);
    push_exp(0, 1'b0, 16'hA5A5);
    req = 4'b0001;
    wait_resp(20);
    req = '0;
    mode = 0;
    @(negedge clk);
    chk("early_done_busy", busy, 1'b0);

    // stray done while idle
    stray_req = stray_req + 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stray_ack_err", {ack, err}, 8'h00);
      chk("stray_rdata", rdata, 16'hA5A5);
      chk("stray_busy", busy, 1'b0);
    end

    // requester 1 appears and withdraws while another transfer runs
    set_word(0, 16'h0F0F);
    set_word(1, 16'h9999);
    push_exp(0, 1'b0, 16'hF0F0);
    req = 4'b0001;
    @(negedge clk);
    req[1] = 1'b1;
    repeat (3) @(negedge clk);
    req[1] = 1'b0;
    wait_resp(200);
    req = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("withdrawn_quiet", {ack, err}, 8'h00);
    end

    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
